// File: rtl/seq_detect_param.sv
// seq_detect_param: parameterised Moore serial-pattern detector with valid qualifier and saturating match counter.
// Define SEQ_DETECT_STATE_DBG_EN to expose the cs/ns fill-level debug ports.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter bit               OVERLAP = 1'b0,
    parameter int               CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in,
    input  logic                        in_valid,
    output logic                        out,
`ifdef SEQ_DETECT_STATE_DBG_EN
    output logic [$clog2(PAT_W+1)-1:0]  cs,
    output logic [$clog2(PAT_W+1)-1:0]  ns,
`endif
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int               FW      = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FULL    = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_n;
    logic [FW-1:0]    fill_next;
    logic             match;

    // A non-overlapping match consumes its bits, so the fill level restarts from zero.
    always_comb begin
        hist_n    = {hist[PAT_W-2:0], in};
        fill_n    = (fill == FULL) ? FULL : fill + 1'b1;
        match     = (fill_n == FULL) && (hist_n == PATTERN);
        fill_next = fill;
        if (in_valid) begin
            fill_next = (match && !OVERLAP) ? '0 : fill_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            out       <= 1'b0;
            match_cnt <= '0;
        end else if (in_valid) begin
            out  <= match;
            fill <= fill_next;
            if (match) begin
                if (match_cnt != CNT_MAX) begin
                    match_cnt <= match_cnt + 1'b1;
                end
                hist <= OVERLAP ? hist_n : '0;
            end else begin
                hist <= hist_n;
            end
        end
    end

`ifdef SEQ_DETECT_STATE_DBG_EN
    assign cs = fill;
    assign ns = fill_next;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: drives three detector configurations with one shared bit stream and
// compares each against an arithmetic reference model of the detection rules.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_def, out_ovl, out_sat;
    logic [7:0] cnt_def, cnt_ovl;
    logic [1:0] cnt_sat;

    int checks = 0;
    int errors = 0;

    // Instance 0: defaults; 1: overlapping 1010; 2: 3-bit 111, overlapping, 2-bit counter.
    int pw   [3] = '{4, 4, 3};
    int pat  [3] = '{10, 10, 7};
    int ovl  [3] = '{0, 1, 1};
    int cmax [3] = '{255, 255, 3};

    int m_hist [3];
    int m_fill [3];
    int m_cnt  [3];
    int m_out  [3];

`ifdef SEQ_DETECT_STATE_DBG_EN
    logic [2:0] cs_def, ns_def, cs_ovl, ns_ovl;
    logic [1:0] cs_sat, ns_sat;
`endif

    seq_detect_param u_def (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .out(out_def),
`ifdef SEQ_DETECT_STATE_DBG_EN
        .cs(cs_def), .ns(ns_def),
`endif
        .match_cnt(cnt_def)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_ovl (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .out(out_ovl),
`ifdef SEQ_DETECT_STATE_DBG_EN
        .cs(cs_ovl), .ns(ns_ovl),
`endif
        .match_cnt(cnt_ovl)
    );

    seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .out(out_sat),
`ifdef SEQ_DETECT_STATE_DBG_EN
        .cs(cs_sat), .ns(ns_sat),
`endif
        .match_cnt(cnt_sat)
    );

    always #5 clk = ~clk;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Fill level the model expects after this edge, ignoring reset.
    function automatic int next_fill(input int k, input bit v, input bit b);
        int h, f;
        if (!v) return m_fill[k];
        h = (m_hist[k] * 2 + b) % (1 << pw[k]);
        f = min_int(m_fill[k] + 1, pw[k]);
        if (f == pw[k] && h == pat[k] && ovl[k] == 0) return 0;
        return f;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit b);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_hist[k] = 0; m_fill[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
            end else if (v) begin
                m_hist[k] = (m_hist[k] * 2 + b) % (1 << pw[k]);
                m_fill[k] = min_int(m_fill[k] + 1, pw[k]);
                if (m_fill[k] == pw[k] && m_hist[k] == pat[k]) begin
                    m_out[k] = 1;
                    m_cnt[k] = min_int(m_cnt[k] + 1, cmax[k]);
                    if (ovl[k] == 0) begin
                        m_fill[k] = 0; m_hist[k] = 0;
                    end
                end else begin
                    m_out[k] = 0;
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_output();
        check_val("out_def", {31'b0, out_def}, m_out[0]);
        check_val("cnt_def", {24'b0, cnt_def}, m_cnt[0]);
        check_val("out_ovl", {31'b0, out_ovl}, m_out[1]);
        check_val("cnt_ovl", {24'b0, cnt_ovl}, m_cnt[1]);
        check_val("out_sat", {31'b0, out_sat}, m_out[2]);
        check_val("cnt_sat", {30'b0, cnt_sat}, m_cnt[2]);
`ifdef SEQ_DETECT_STATE_DBG_EN
        check_val("cs_def", {29'b0, cs_def}, m_fill[0]);
        check_val("cs_ovl", {29'b0, cs_ovl}, m_fill[1]);
        check_val("cs_sat", {30'b0, cs_sat}, m_fill[2]);
`endif
    endtask

    // Present one cycle of inputs, clock it, then compare every instance with the model.
    task automatic apply_stimulus(input bit r, input bit v, input bit b);
        rst = r; in_valid = v; in = b;
        #1;
`ifdef SEQ_DETECT_STATE_DBG_EN
        if (!r) begin
            check_val("ns_def", {29'b0, ns_def}, next_fill(0, v, b));
            check_val("ns_ovl", {29'b0, ns_ovl}, next_fill(1, v, b));
            check_val("ns_sat", {30'b0, ns_sat}, next_fill(2, v, b));
        end
`endif
        @(posedge clk);
        #1;
        model_step(r, v, b);
        check_output();
    endtask

    task automatic feed(input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) apply_stimulus(1'b0, 1'b1, bits[i]);
    endtask

    initial begin
        logic [15:0] seq;
        // Reset state, including a bit presented during reset that must be dropped.
        apply_stimulus(1'b1, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0);

        // 101010 stream: one match non-overlapping, two with overlap.
        seq = 16'b101010;
        feed(6, seq);
        check_val("plan_cnt_def_101010", {24'b0, cnt_def}, 1);
        check_val("plan_cnt_ovl_101010", {24'b0, cnt_ovl}, 2);

        // Stalls around 1010: detection delayed, out held through a gap.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_val("plan_out_held", {31'b0, out_def}, 1);

        // Reset mid-pattern discards the partial match.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        seq = 16'b101;
        feed(3, seq);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        seq = 16'b010;
        feed(3, seq);
        check_val("plan_cnt_after_midreset", {24'b0, cnt_def}, 0);

        // Eight ones: 3-bit 111 detector matches from bit 3 and saturates at 3.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        seq = 16'hFF;
        feed(8, seq);
        check_val("plan_cnt_sat", {30'b0, cnt_sat}, 3);

        // Randomised stream with stalls and occasional resets.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(99) < 2, $urandom_range(99) < 75, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
